// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - pipeline control FSM encodings and parameter defaults
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } pipe_state_t;

    localparam int WAIT_MAX_DEF = 255;
    localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating event counter, holds at all-ones
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - MIPS pipeline stall/flush controller; PIPE_CTRL_STATS_EN adds stall/flush counters
module pipe_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       mem_branch,
    input  logic       mem_zero,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       idex_we,
    output logic       exmem_we,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       memwb_bubble,
    output logic [1:0] state,
    output logic       err
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    pipe_state_t       cur_state, nxt_state;
    logic [WAIT_W-1:0] wait_cnt, nxt_wait;
    logic              load_use, taken, mem_stall;

    assign load_use  = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign taken     = mem_branch && mem_zero;
    assign mem_stall = dmem_req && !dmem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_RUN;
            wait_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= nxt_wait;
        end
    end

    always_comb begin
        nxt_state    = cur_state;
        nxt_wait     = wait_cnt;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        exmem_we     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        case (cur_state)
            ST_RUN: begin
                nxt_wait = '0;
                if (mem_stall) begin
                    {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
                    memwb_bubble = 1'b1;
                    nxt_state    = ST_MEM_WAIT;
                end else if (taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    nxt_state = ST_RUN;
                    nxt_wait  = '0;
                end else begin
                    {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
                    memwb_bubble = 1'b1;
                    nxt_wait     = wait_cnt + 1'b1;
                    // The cycle that brings the count to WAIT_MAX is the last one tolerated
                    if (wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
                        nxt_state = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
            end
            default: begin
                nxt_state = ST_RUN;
                nxt_wait  = '0;
            end
        endcase
        // Reset forces every control low, not just the registered state
        if (reset) begin
            {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
            {ifid_flush, idex_flush, exmem_flush, memwb_bubble} = 4'b0000;
        end
    end

    assign state = cur_state;
    assign err   = (cur_state == ST_ERR);

`ifdef PIPE_CTRL_STATS_EN
    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_we && (cur_state != ST_ERR)),
        .count (stall_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ifid_flush),
        .count (flush_cnt)
    );
`else
    logic [CNT_W-1:0] stats_unused;
    assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed bench for pipe_ctrl; stats checks active with PIPE_CTRL_STATS_EN
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_memread, mem_branch, mem_zero, dmem_req, dmem_ready;
    logic       pc_we, ifid_we, idex_we, exmem_we;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_bubble;
    logic [1:0] state;
    logic       err;
`ifdef PIPE_CTRL_STATS_EN
    logic [1:0] stall_cnt, flush_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [7:0] C_RUN   = 8'b1111_0000;
    localparam logic [7:0] C_LU    = 8'b0011_0100;
    localparam logic [7:0] C_BR    = 8'b1111_1110;
    localparam logic [7:0] C_STALL = 8'b0000_0001;
    localparam logic [7:0] C_OFF   = 8'b0000_0000;

    pipe_ctrl #(.WAIT_MAX(4), .CNT_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .mem_branch   (mem_branch),
        .mem_zero     (mem_zero),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .idex_we      (idex_we),
        .exmem_we     (exmem_we),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .memwb_bubble (memwb_bubble),
        .state        (state),
        .err          (err)
`ifdef PIPE_CTRL_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    wire [7:0] ctl = {pc_we, ifid_we, idex_we, exmem_we,
                      ifid_flush, idex_flush, exmem_flush, memwb_bubble};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; ex_memread = 1'b0;
        mem_branch = 1'b0; mem_zero = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        chk("rst_ctl", ctl, C_OFF);
        chk("rst_state", {6'd0, state}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("run_default", ctl, C_RUN);

        // load-use through rs, through rt, then no-hazard variants
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
        chk("lu_rs", ctl, C_LU);
        tick(); idle(); #1;
        chk("lu_next", ctl, C_RUN);
        ex_memread = 1'b1; ex_rt = 5'd8; id_rt = 5'd8; #1;
        chk("lu_rt", ctl, C_LU);
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; #1;
        chk("lu_r0", ctl, C_RUN);
        ex_memread = 1'b0; ex_rt = 5'd8; id_rs = 5'd8; #1;
        chk("no_memread", ctl, C_RUN);

        // taken branch dominates load-use; untaken branch does nothing
        tick();
        ex_memread = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1; #1;
        chk("br_taken", ctl, C_BR);
        tick(); idle(); mem_branch = 1'b1; #1;
        chk("br_not_taken", ctl, C_RUN);

        // memory wait with a taken branch in the entry cycle
        tick();
        dmem_req = 1'b1; mem_zero = 1'b1; #1;
        chk("mw_entry", ctl, C_STALL);
        chk("mw_entry_st", {6'd0, state}, 8'd0);
        tick(); mem_branch = 1'b0; mem_zero = 1'b0; #1;
        chk("mw1_st", {6'd0, state}, 8'd1);
        chk("mw1_ctl", ctl, C_STALL);
        tick(); #1;
        chk("mw2_st", {6'd0, state}, 8'd1);
        chk("mw2_ctl", ctl, C_STALL);
        dmem_ready = 1'b1; #1;
        chk("mw_ready_ctl", ctl, C_RUN);
        chk("mw_ready_st", {6'd0, state}, 8'd1);
        tick(); idle(); #1;
        chk("mw_done_st", {6'd0, state}, 8'd0);
        chk("mw_done_ctl", ctl, C_RUN);

        // timeout: entry cycle then four wait cycles with ready low
        dmem_req = 1'b1; #1;
        chk("to_entry", ctl, C_STALL);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("to_wait_st", {6'd0, state}, 8'd1);
            chk("to_wait_ctl", ctl, C_STALL);
        end
        tick(); #1;
        chk("to_err_st", {6'd0, state}, 8'd2);
        chk("to_err", {7'd0, err}, 8'd1);
        chk("to_err_ctl", ctl, C_OFF);
        dmem_ready = 1'b1; ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        mem_branch = 1'b1; mem_zero = 1'b1;
        tick(); #1;
        chk("err_sticky_st", {6'd0, state}, 8'd2);
        chk("err_sticky_ctl", ctl, C_OFF);
        reset = 1'b1; #1;
        chk("err_rst_st", {6'd0, state}, 8'd0);
        chk("err_rst_err", {7'd0, err}, 8'd0);
        chk("err_rst_ctl", ctl, C_OFF);
        tick(); reset = 1'b0; idle(); #1;
        chk("err_rel_ctl", ctl, C_RUN);

        // asynchronous reset in the second wait cycle
        dmem_req = 1'b1;
        tick(); tick(); #1;
        chk("rmw_st", {6'd0, state}, 8'd1);
        reset = 1'b1; #1;
        chk("rmw_async_st", {6'd0, state}, 8'd0);
        chk("rmw_async_ctl", ctl, C_OFF);
        tick(); reset = 1'b0; idle(); #1;
        chk("rmw_rel_ctl", ctl, C_RUN);
        chk("rmw_rel_st", {6'd0, state}, 8'd0);

`ifdef PIPE_CTRL_STATS_EN
        chk("stat_rst_stall", {6'd0, stall_cnt}, 8'd0);
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        for (int i = 0; i < 5; i++) tick();
        chk("stat_stall_sat", {6'd0, stall_cnt}, 8'd3);
        idle(); mem_branch = 1'b1; mem_zero = 1'b1;
        tick(); tick(); idle(); #1;
        chk("stat_flush", {6'd0, flush_cnt}, 8'd2);
        chk("stat_stall_hold", {6'd0, stall_cnt}, 8'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 255, SHALL set the max consecutive data-memory wait cycles before error.
REQ-002 Parameter CNT_W, default 16, SHALL set the statistics counter width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 reset  in  1  SHALL be asynchronous, active-high reset.
REQ-005 id_rs, id_rt  in  5 each  SHALL be the source register numbers of the instruction in ID.
REQ-006 ex_memread  in  1, ex_rt  in  5  SHALL identify a load in EX and its destination register.
REQ-007 mem_branch  in  1, mem_zero  in  1  SHALL be the branch control bit and ULA zero flag latched in EX/MEM.
REQ-008 dmem_req  in  1, dmem_ready  in  1  SHALL be the MEM-stage access request and memory-completion handshake.
REQ-009 pc_we, ifid_we, idex_we, exmem_we  out  1 each  SHALL be the stage write enables.
REQ-010 ifid_flush, idex_flush, exmem_flush  out  1 each  SHALL be synchronous bubble-insert controls for the pipeline registers.
REQ-011 memwb_bubble  out  1  SHALL force a no-op into MEM/WB.
REQ-012 state  out  2  SHALL expose the FSM state; err  out  1  SHALL be the sticky timeout flag.

Function
REQ-013 The FSM SHALL have states RUN=0, MEM_WAIT=1, ERR=2; encoding 3 SHALL be unreachable and SHALL recover to RUN.
REQ-014 Control outputs SHALL be combinational from state and current inputs, giving same-cycle (zero-latency) stall and flush.
REQ-015 Priority order SHALL be: ERR > memory wait > taken branch > load-use.
REQ-016 Memory wait: in RUN, dmem_req=1 with dmem_ready=0 SHALL drive all *_we=0 and memwb_bubble=1, and SHALL go to MEM_WAIT.
REQ-017 In MEM_WAIT, outputs SHALL match REQ-016 while dmem_ready=0, and a wait counter SHALL increment each cycle.
REQ-018 In MEM_WAIT, dmem_ready=1 SHALL give all *_we=1 and memwb_bubble=0 in that cycle, then return to RUN with the counter cleared.
REQ-019 Timeout: dmem_ready still 0 when the counter reaches WAIT_MAX SHALL enter ERR and set err=1.
REQ-020 In ERR, all *_we SHALL be 0 and all flushes 0; ERR SHALL be left only by reset.
REQ-021 Taken branch: in RUN without memory wait, mem_branch=1 and mem_zero=1 SHALL assert ifid_flush, idex_flush and exmem_flush for exactly that cycle, with all *_we=1.
REQ-022 A taken branch SHALL suppress any simultaneous load-use stall.
REQ-023 Load-use: ex_memread=1, ex_rt!=0 and ex_rt equal to id_rs or id_rt SHALL give pc_we=0, ifid_we=0 and idex_flush=1, with exmem_we=1, for one cycle.
REQ-024 ex_rt=0 SHALL never cause a stall.
REQ-025 With no event in RUN, all *_we SHALL be 1 and all flushes/bubbles 0.

Reset
REQ-026 While reset=1: state=RUN, wait counter=0, err=0, all *_we=0, all flushes=0, memwb_bubble=0, statistics=0.
REQ-027 Reset asserted mid-MEM_WAIT or in ERR SHALL return to RUN immediately (asynchronously).

Configuration
REQ-028 With macro PIPE_CTRL_STATS_EN defined, outputs stall_cnt and flush_cnt (CNT_W bits each) SHALL exist.
REQ-029 stall_cnt SHALL count cycles with pc_we=0 outside ERR; flush_cnt SHALL count taken-branch flush cycles.
REQ-030 Both counters SHALL saturate at all-ones.
REQ-031 Without PIPE_CTRL_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-032 Package mips_pipe_pkg SHALL hold the FSM state typedef/encodings and the WAIT_MAX and CNT_W defaults.
REQ-033 The saturating counter SHALL be a sub-module, pipe_sat_cnt, instantiated twice under PIPE_CTRL_STATS_EN.

Verification
REQ-034 Load-use: ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1; next cycle all *_we=1.
REQ-035 Taken branch: mem_branch=1, mem_zero=1, plus load-use on ex_rt=8 -> three flushes=1, pc_we=1, no stall; mem_zero=0 -> no flush.
REQ-036 Memory wait: dmem_req=1, dmem_ready low 3 cycles then high -> state=1 for 3 cycles, *_we=0, memwb_bubble=1; ready cycle *_we=1; then state=0.
REQ-037 Timeout: WAIT_MAX=4, dmem_ready held 0 -> state=2 and err=1 after 4 wait cycles; reset pulse -> state=0, err=0.
REQ-038 Reset mid-wait: reset in 2nd MEM_WAIT cycle -> state=0 and all outputs 0 asynchronously; after release, RUN defaults.
REQ-039 Stats (PIPE_CTRL_STATS_EN, CNT_W=2): 5 stall cycles -> stall_cnt=3 (saturated).
